// File: rtl/vec_mem_agent.sv
// vec_mem_agent: A/B/C operand memories feeding a vector MAC core; results written back into C.
// Latency: operands are combinational from memory at rd_idx; host_rdata is registered (1 cycle); done follows the last captured result.
// Backpressure: op_valid/op_ready handshake; operands hold while op_ready=0; host writes while busy are dropped.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   host_we/sel/addr/wdata host load of A (sel=0), B (1), C (2); sel=3 drops the write
//   host_raddr/host_rdata  registered readback of C
//   start, n               launch a run over min(n, DEPTH) elements
//   busy, done, len_err    run status; done is a one-cycle pulse; len_err is sticky until next start
//   op_valid/op_ready      operand triple handshake carrying a_data, b_data, c_data_in
//   res_valid/res_data     in-order result stream from the core, stored into C[wr_idx]
//   checksum               present only with VEC_MEM_AGENT_CHECKSUM_EN: sum of results accepted this run
module vec_mem_agent #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_we,
    input  logic [1:0]    host_sel,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic [AW-1:0] host_raddr,
    output logic [DW-1:0] host_rdata,
    input  logic          start,
    input  logic [31:0]   n,
    output logic          busy,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] a_data,
    output logic [DW-1:0] b_data,
    output logic [DW-1:0] c_data_in,
    input  logic          res_valid,
    input  logic [DW-1:0] res_data,
    output logic          done,
`ifdef VEC_MEM_AGENT_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output logic          len_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] rd_idx;
    // One extra bit so that wr_idx can reach len when len == DEPTH.
    logic [AW:0]   wr_idx;
    logic [AW:0]   len;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    logic [DW-1:0] mem_c [DEPTH];

    logic start_acc;
    logic xfer;
    logic last_xfer;
    logic res_acc;
    logic host_wr;

    // Next-state and outputs.
    always_comb begin
        state_nx  = state;
        op_valid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        a_data    = '0;
        b_data    = '0;
        c_data_in = '0;
        start_acc = 1'b0;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        res_acc   = 1'b0;
        host_wr   = 1'b0;

        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                host_wr   = host_we;
                start_acc = start;
                if (start) begin
                    state_nx = (n == 32'd0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                op_valid  = 1'b1;
                // Memory reads see pre-edge contents, so a same-cycle
                // write to the same index is not forwarded.
                a_data    = mem_a[rd_idx];
                b_data    = mem_b[rd_idx];
                c_data_in = mem_c[rd_idx];
                xfer      = op_ready;
                last_xfer = op_ready && ({1'b0, rd_idx} == (len - 1'b1));
                res_acc   = res_valid && (wr_idx < len);
                if (last_xfer) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                res_acc = res_valid && (wr_idx < len);
                if (wr_idx == len) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_idx     <= '0;
            wr_idx     <= '0;
            len        <= '0;
            len_err    <= 1'b0;
            host_rdata <= '0;
`ifdef VEC_MEM_AGENT_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            state      <= state_nx;
            host_rdata <= mem_c[host_raddr];
            if (start_acc) begin
                rd_idx  <= '0;
                wr_idx  <= '0;
                len     <= (n > 32'(DEPTH)) ? DEPTH_L : n[AW:0];
                len_err <= (n > 32'(DEPTH));
`ifdef VEC_MEM_AGENT_CHECKSUM_EN
                checksum <= '0;
`endif
            end else begin
                if (xfer) begin
                    rd_idx <= rd_idx + 1'b1;
                end
                if (res_acc) begin
                    wr_idx <= wr_idx + 1'b1;
`ifdef VEC_MEM_AGENT_CHECKSUM_EN
                    checksum <= checksum + res_data;
`endif
                end
            end
        end
    end

    // Memories are never reset; host writes only happen in IDLE and result
    // writes only in ISSUE/DRAIN, so the two C write paths never collide.
    always_ff @(posedge clk) begin
        if (host_wr) begin
            case (host_sel)
                2'd0:    mem_a[host_addr] <= host_wdata;
                2'd1:    mem_b[host_addr] <= host_wdata;
                2'd2:    mem_c[host_addr] <= host_wdata;
                default: ;
            endcase
        end
        if (res_acc) begin
            mem_c[wr_idx[AW-1:0]] <= res_data;
        end
    end

endmodule
